// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART receiver: register map, STATUS bit positions, FSM states.
// WB_UART_RX_PARITY_EN adds the PARITY state and the parity_odd STATUS bit.
package wb_uart_pkg;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;
  localparam logic [1:0] UART_REG_DIV    = 2'd2;

  localparam int STAT_NOT_EMPTY  = 0;
  localparam int STAT_FULL       = 1;
  localparam int STAT_OVERRUN    = 2;
  localparam int STAT_FRAME_ERR  = 3;
  localparam int STAT_PARITY_ERR = 4;
`ifdef WB_UART_RX_PARITY_EN
  localparam int STAT_PARITY_ODD = 5;
`endif
  localparam int STAT_LEVEL_LSB  = 8;

`ifdef WB_UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK
  } rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous RX byte FIFO. Pop while empty is a no-op; push while full succeeds only
// when a pop frees a slot in the same cycle, otherwise the byte is dropped.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  // count only reaches 2^N when full, so its top bit is the full flag
  assign full    = count[DEPTH_LOG2];
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_rx.sv
// Wishbone-classic UART receiver: 2-flop synchronizer, 16x oversampled 8N1 deframer, RX FIFO.
// Define WB_UART_RX_PARITY_EN to receive a parity bit (STATUS bit4 parity_err, bit5 parity_odd).
module wb_uart_rx #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DEFAULT_DIVISOR = 13,
  parameter int DIV_WIDTH       = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        uart_rx,
  output logic        rx_irq_o
);

  import wb_uart_pkg::*;

  logic                   rx_meta;
  logic                   rx_s;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   div_eff;
  logic [DIV_WIDTH-1:0]   cnt_q;
  logic                   tick;
  logic                   start_enter;

  rx_state_t              state_q;
  logic [3:0]             phase_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shreg_q;
  logic                   push_q;
  logic                   frame_set_q;

  logic                   overrun_q;
  logic                   frame_err_q;
  logic                   parity_err_q;
  logic                   overrun_set;

  logic                   ack_q;
  logic [31:0]            dat_q;
  logic                   req;
  logic                   stat_wr;
  logic                   div_wr;
  logic                   fifo_pop;
  logic [31:0]            rd_data;
  logic [31:0]            status_word;

  logic [7:0]             fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FIFO_DEPTH_LOG2:0] fifo_level;

  logic                   unused_bits;
  assign unused_bits = &{1'b0, wb_sel_i, wb_dat_i};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Oversampling tick; restarting on START entry aligns samples to the falling start edge
  assign div_eff     = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign tick        = (cnt_q == '0);
  assign start_enter = (state_q == ST_IDLE) && !rx_s;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else if (start_enter || tick) begin
      cnt_q <= div_eff - DIV_WIDTH'(1);
    end else begin
      cnt_q <= cnt_q - DIV_WIDTH'(1);
    end
  end

`ifdef WB_UART_RX_PARITY_EN
  logic parity_odd_q;
  logic parity_set_q;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_set_q <= 1'b0;
`ifdef WB_UART_RX_PARITY_EN
      parity_set_q <= 1'b0;
`endif
    end else begin
      push_q      <= 1'b0;
      frame_set_q <= 1'b0;
`ifdef WB_UART_RX_PARITY_EN
      parity_set_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_START;
            phase_q <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (phase_q == 4'd7) begin
              phase_q <= '0;
              if (!rx_s) begin
                state_q   <= ST_DATA;
                bit_cnt_q <= '0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              phase_q <= phase_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd15) begin
              shreg_q   <= {rx_s, shreg_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
`ifdef WB_UART_RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end
            end
          end
        end
`ifdef WB_UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd15) begin
              parity_set_q <= (rx_s != (^shreg_q ^ parity_odd_q));
              state_q      <= ST_STOP;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd15) begin
              if (rx_s) begin
                push_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                frame_set_q <= 1'b1;
                state_q     <= ST_BREAK;
              end
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push_q),
    .push_data (shreg_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Handshake: ack rises the cycle after cyc&stb is seen with ack low, for one cycle only;
  // read data and every register side effect are committed on that same edge.
  assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
  assign stat_wr  = req & wb_we_i & (wb_adr_i == UART_REG_STATUS);
  assign div_wr   = req & wb_we_i & (wb_adr_i == UART_REG_DIV);
  assign fifo_pop = req & ~wb_we_i & (wb_adr_i == UART_REG_DATA);

  assign overrun_set = push_q & fifo_full & ~fifo_pop;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_set | (overrun_q & ~(stat_wr & wb_dat_i[STAT_OVERRUN]));
      frame_err_q <= frame_set_q | (frame_err_q & ~(stat_wr & wb_dat_i[STAT_FRAME_ERR]));
    end
  end

`ifdef WB_UART_RX_PARITY_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      parity_err_q <= 1'b0;
      parity_odd_q <= 1'b0;
    end else begin
      parity_err_q <= parity_set_q | (parity_err_q & ~(stat_wr & wb_dat_i[STAT_PARITY_ERR]));
      if (stat_wr) begin
        parity_odd_q <= wb_dat_i[STAT_PARITY_ODD];
      end
    end
  end
`else
  assign parity_err_q = 1'b0;
`endif

  always_comb begin
    status_word                 = '0;
    status_word[STAT_NOT_EMPTY]  = ~fifo_empty;
    status_word[STAT_FULL]       = fifo_full;
    status_word[STAT_OVERRUN]    = overrun_q;
    status_word[STAT_FRAME_ERR]  = frame_err_q;
    status_word[STAT_PARITY_ERR] = parity_err_q;
`ifdef WB_UART_RX_PARITY_EN
    status_word[STAT_PARITY_ODD] = parity_odd_q;
`endif
    status_word[STAT_LEVEL_LSB +: FIFO_DEPTH_LOG2 + 1] = fifo_level;
  end

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      UART_REG_DATA:   rd_data[7:0] = fifo_empty ? 8'h00 : fifo_head;
      UART_REG_STATUS: rd_data = status_word;
      UART_REG_DIV:    rd_data[DIV_WIDTH-1:0] = div_q;
      default:         rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      div_q <= DIV_WIDTH'(DEFAULT_DIVISOR);
    end else begin
      ack_q <= req;
      dat_q <= (req && !wb_we_i) ? rd_data : '0;
      if (div_wr) begin
        div_q <= wb_dat_i[DIV_WIDTH-1:0];
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign rx_irq_o = ~fifo_empty | overrun_q | frame_err_q | parity_err_q;

endmodule

// File: tb/tb_wb_uart_rx.sv
// Self-checking bench for wb_uart_rx: register vector table, serial-frame corner sequences,
// and random traffic checked against a queue model of the receive FIFO and its flags.
module tb_wb_uart_rx;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_DIV  = 2'd2;
  localparam logic [1:0] A_RSV  = 2'd3;
`ifdef WB_UART_RX_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  adr = '0;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel = 4'hF;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] dat_o;
  logic        ack;
  logic        uart_rx = 1'b1;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int div_cur  = 13;

  logic [7:0] exp_q[$];
  logic       exp_ovr;

  wb_uart_rx dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .uart_rx  (uart_rx),
    .rx_irq_o (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  adr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] r);
    int lat;
    @(posedge clk); #1;
    adr = a; we = w; dat_i = d; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 8);
    r = dat_o;
    check("ack_latency", ack ? 32'(lat) : 32'd0, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    logic [31:0] r;
    wb_xfer(a, 1'b0, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(a, 1'b1, d, r);
  endtask

  task automatic line(input logic v, input int cycles);
    uart_rx = v;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic use_par,
                            input logic pbit);
    int bt;
    bt = 16 * div_cur;
    line(1'b0, bt);
    for (int i = 0; i < 8; i++) line(b[i], bt);
    if (use_par) line(pbit, bt);
    line(stop_bit, bt);
    uart_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, PAR_ON, ^b);
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s       = '0;
    s[15:8] = 8'(exp_q.size());
    s[2]    = exp_ovr;
    s[1]    = (exp_q.size() == 16);
    s[0]    = (exp_q.size() != 0);
    return s;
  endfunction

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  pat;
    logic [7:0]  b;
    logic [7:0]  e;
    int          k;

    vecs[0]  = '{"rst_status",   A_STAT, 1'b0, 32'h0,         32'h0};
    vecs[1]  = '{"rst_div",      A_DIV,  1'b0, 32'h0,         32'd13};
    vecs[2]  = '{"empty_data",   A_DATA, 1'b0, 32'h0,         32'h0};
    vecs[3]  = '{"rsv_read",     A_RSV,  1'b0, 32'h0,         32'h0};
    vecs[4]  = '{"rsv_write",    A_RSV,  1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{"rsv_reread",   A_RSV,  1'b0, 32'h0,         32'h0};
    vecs[6]  = '{"div_write",    A_DIV,  1'b1, 32'hABCD_1234, 32'h0};
    vecs[7]  = '{"div_readback", A_DIV,  1'b0, 32'h0,         32'h0000_1234};
    vecs[8]  = '{"data_write",   A_DATA, 1'b1, 32'h0000_005A, 32'h0};
    vecs[9]  = '{"data_wr_ign",  A_STAT, 1'b0, 32'h0,         32'h0};
    vecs[10] = '{"w1c_noflags",  A_STAT, 1'b1, 32'h0000_001C, 32'h0};
    vecs[11] = '{"w1c_status",   A_STAT, 1'b0, 32'h0,         32'h0};
    vecs[12] = '{"div_restore",  A_DIV,  1'b1, 32'd13,        32'h0};
    vecs[13] = '{"div_13",       A_DIV,  1'b0, 32'h0,         32'd13};

    repeat (5) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq", {31'b0, irq}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].wdata, r);
      if (!vecs[i].we) check(vecs[i].name, r, vecs[i].exp);
    end

    // stb held for four cycles: ack must alternate, never two in a row
    @(posedge clk); #1;
    adr = A_STAT; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    check("ack_alternate", {28'b0, pat}, 32'h5);

    // two characters, then drain past empty
    send_byte(8'hA5);
    send_byte(8'h3C);
    rd(A_STAT, 32'h0000_0201, "two_status");
    check("two_irq", {31'b0, irq}, 32'd1);
    rd(A_DATA, 32'hA5, "two_data0");
    check("two_irq_mid", {31'b0, irq}, 32'd1);
    rd(A_DATA, 32'h3C, "two_data1");
    check("two_irq_drop", {31'b0, irq}, 32'd0);
    rd(A_DATA, 32'h0, "two_underflow");
    rd(A_STAT, 32'h0, "two_status_empty");

    // short glitch must not be taken as a start bit
    line(1'b0, 5);
    line(1'b1, 2 * 16 * div_cur);
    rd(A_STAT, 32'h0, "glitch_status");
    check("glitch_irq", {31'b0, irq}, 32'd0);

    // 17 characters into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_byte(8'(i));
    rd(A_STAT, 32'h0000_1007, "ovr_status");
    for (int i = 0; i < 16; i++) rd(A_DATA, 32'(i), "ovr_data");
    rd(A_STAT, 32'h0000_0004, "ovr_sticky");
    check("ovr_irq", {31'b0, irq}, 32'd1);
    wr(A_STAT, 32'h4);
    rd(A_STAT, 32'h0, "ovr_cleared");

    // framing error, then a long break, then recovery
    send_frame(8'h55, 1'b0, PAR_ON, ^8'h55);
    line(1'b1, 16 * div_cur);
    rd(A_STAT, 32'h0000_0008, "frame_status");
    check("frame_irq", {31'b0, irq}, 32'd1);
    wr(A_STAT, 32'h8);
    rd(A_STAT, 32'h0, "frame_cleared");
    line(1'b0, 40 * 16 * div_cur);
    line(1'b1, 2 * 16 * div_cur);
    rd(A_STAT, 32'h0000_0008, "break_status");
    wr(A_STAT, 32'h8);
    send_byte(8'h12);
    rd(A_STAT, 32'h0000_0101, "recover_status");
    rd(A_DATA, 32'h12, "recover_data");

`ifdef WB_UART_RX_PARITY_EN
    wr(A_STAT, 32'h0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    rd(A_STAT, 32'h0000_0111, "par_bad_status");
    rd(A_DATA, 32'h07, "par_bad_data");
    wr(A_STAT, 32'h10);
    rd(A_STAT, 32'h0, "par_cleared");
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    rd(A_STAT, 32'h0000_0101, "par_good_status");
    rd(A_DATA, 32'h07, "par_good_data");
    wr(A_STAT, 32'h20);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    rd(A_STAT, 32'h0000_0121, "par_odd_status");
    rd(A_DATA, 32'h07, "par_odd_data");
    wr(A_STAT, 32'h0);
`endif

    // random traffic against the queue model
    exp_q.delete();
    exp_ovr = 1'b0;
    div_cur = $urandom_range(2, 4);
    wr(A_DIV, 32'(div_cur));
    rd(A_DIV, 32'(div_cur), "rand_div");
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b);
      if (exp_q.size() < 16) exp_q.push_back(b);
      else exp_ovr = 1'b1;
      rd(A_STAT, model_status(), "rand_status");
      check("rand_irq", {31'b0, irq}, {31'b0, (exp_q.size() != 0) | exp_ovr});
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        e = 8'h00;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        rd(A_DATA, {24'b0, e}, "rand_data");
      end
    end

    // reset in the middle of a frame and of a bus access
    send_byte(8'h81);
    uart_rx = 1'b0;
    repeat (4 * 16 * div_cur) @(posedge clk);
    #1;
    adr = A_STAT; we = 1'b0; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack", {31'b0, ack}, 32'd0);
    check("rst_mid_dat", dat_o, 32'h0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; uart_rx = 1'b1;
    div_cur = 13;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_irq", {31'b0, irq}, 32'd0);
    rd(A_STAT, 32'h0, "rst_mid_status");
    rd(A_DIV, 32'd13, "rst_mid_div");
    send_byte(8'h3C);
    rd(A_STAT, 32'h0000_0101, "post_rst_status");
    rd(A_DATA, 32'h3C, "post_rst_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
